// File: rtl/core_selftest.sv
// core_selftest: built-in self-test sequencer for a core under test.
// Holds the core in reset, lets it free-run, then stalls it and walks its
// registers through a debug read port, comparing each against an expected
// table and reporting pass/fail.
//
// Optional feature macro: SELFTEST_STOP_ON_FAIL_EN (stop at first mismatch).
//
// Ports:
//   clk, reset          clock, asynchronous active-high reset
//   start               begin a test (accepted in IDLE or DONE)
//   core_reset          reset to the core under test
//   core_stall          freeze the core while it is being checked
//   chk_addr            register index for debug read and expected table
//   dbg_data            core register value at chk_addr (combinational)
//   exp_data, exp_mask  expected value and check-enable at chk_addr
//   busy, done, pass    test status
//   fail_idx            index of first mismatching register
//   err_count           number of mismatches
//   LED                 done AND pass
module core_selftest #(
  parameter int unsigned DATA_WIDTH   = 32,
  parameter int unsigned NUM_REGS     = 32,
  parameter int unsigned RESET_CYCLES = 2,
  parameter int unsigned RUN_CYCLES   = 2500,
  localparam int unsigned AW = $clog2(NUM_REGS),
  localparam int unsigned CW = $clog2(NUM_REGS + 1)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  output logic                  core_reset,
  output logic                  core_stall,
  output logic [AW-1:0]         chk_addr,
  input  logic [DATA_WIDTH-1:0] dbg_data,
  input  logic [DATA_WIDTH-1:0] exp_data,
  input  logic                  exp_mask,
  output logic                  busy,
  output logic                  done,
  output logic                  pass,
  output logic [AW-1:0]         fail_idx,
  output logic [CW-1:0]         err_count,
  output logic                  LED
);

  localparam int unsigned CNT_MAX = (RESET_CYCLES > RUN_CYCLES) ? RESET_CYCLES : RUN_CYCLES;
  localparam int unsigned CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    HOLD  = 3'd1,
    RUN   = 3'd2,
    CHECK = 3'd3,
    DONE  = 3'd4
  } state_t;

  state_t          state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [AW-1:0]   addr_q, addr_d;
  logic [AW-1:0]   fidx_q, fidx_d;
  logic [CW-1:0]   err_q, err_d;
  logic            pass_q, pass_d;
  logic            core_reset_q, core_reset_d;
  logic            core_stall_q, core_stall_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic            led_q, led_d;
  logic            mismatch_c;

  // Masked full-width compare of the register currently addressed.
  assign mismatch_c = (state_q == CHECK) && exp_mask && (dbg_data != exp_data);

  // State, counters and registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      addr_q       <= '0;
      fidx_q       <= '0;
      err_q        <= '0;
      pass_q       <= 1'b0;
      core_reset_q <= 1'b1;
      core_stall_q <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      led_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      addr_q       <= addr_d;
      fidx_q       <= fidx_d;
      err_q        <= err_d;
      pass_q       <= pass_d;
      core_reset_q <= core_reset_d;
      core_stall_q <= core_stall_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      led_q        <= led_d;
    end
  end

  // Next-state, result bookkeeping and next-output decode.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = '0;
    fidx_d  = fidx_q;
    err_d   = err_q;
    pass_d  = pass_q;

    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d = HOLD;
          cnt_d   = '0;
          fidx_d  = '0;
          err_d   = '0;
          pass_d  = 1'b0;
        end
      end
      HOLD: begin
        if (cnt_q == CNT_W'(RESET_CYCLES - 1)) begin
          state_d = RUN;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      RUN: begin
        if (cnt_q == CNT_W'(RUN_CYCLES - 1)) begin
          state_d = CHECK;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      CHECK: begin
        addr_d = addr_q + 1'b1;
        if (mismatch_c) begin
          err_d = err_q + 1'b1;
          if (err_q == '0) fidx_d = addr_q;
        end
        if (addr_q == AW'(NUM_REGS - 1)) begin
          state_d = DONE;
          addr_d  = '0;
        end
`ifdef SELFTEST_STOP_ON_FAIL_EN
        if (mismatch_c) begin
          state_d = DONE;
          addr_d  = '0;
        end
`endif
      end
      default: state_d = IDLE;
    endcase

    // Verdict includes the comparison registered on the DONE-entry edge.
    if ((state_d == DONE) && (state_q != DONE)) pass_d = (err_d == '0);

    core_reset_d = (state_d == IDLE) || (state_d == HOLD);
    core_stall_d = (state_d == CHECK) || (state_d == DONE);
    busy_d       = (state_d == HOLD) || (state_d == RUN) || (state_d == CHECK);
    done_d       = (state_d == DONE);
    led_d        = done_d && pass_d;
  end

  assign core_reset = core_reset_q;
  assign core_stall = core_stall_q;
  assign chk_addr   = addr_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign pass       = pass_q;
  assign fail_idx   = fidx_q;
  assign err_count  = err_q;
  assign LED        = led_q;

endmodule

// File: doc/core_selftest.md
CORE_SELFTEST -- requirements
Module: core_selftest

Interface
- REQ-001 SHALL have parameter DATA_WIDTH, default 32, the width of the checked register values.
- REQ-002 SHALL have parameter NUM_REGS, default 32, the number of registers checked (>=2).
- REQ-003 SHALL have parameter RESET_CYCLES, default 2, the number of cycles the core is held in reset after start (>=1).
- REQ-004 SHALL have parameter RUN_CYCLES, default 2500, the number of free-run cycles the core is given before checking (>=1).
- REQ-005 SHALL derive AW = clog2(NUM_REGS) and CW = clog2(NUM_REGS+1) locally.
- REQ-006 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
- REQ-007 SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
- REQ-008 SHALL have port start, input, 1 bit: a request to begin a test; sampled on clk.
- REQ-009 SHALL have port core_reset, output, 1 bit: reset to the core under test.
- REQ-010 SHALL have port core_stall, output, 1 bit: freezes the core's state while it is being checked.
- REQ-011 SHALL have port chk_addr, output, AW bits: register index driven to the core's debug read port and to the expected-value table.
- REQ-012 SHALL have port dbg_data, input, DATA_WIDTH bits: the core register value at chk_addr, combinational and valid in the same cycle.
- REQ-013 SHALL have port exp_data, input, DATA_WIDTH bits: the expected value for chk_addr, combinational.
- REQ-014 SHALL have port exp_mask, input, 1 bit: 1 means chk_addr is checked; 0 means it is skipped.
- REQ-015 SHALL have outputs busy (1 bit), done (1 bit), pass (1 bit), fail_idx (AW bits), err_count (CW bits) and LED (1 bit).

Function
- REQ-016 SHALL implement the states IDLE, HOLD, RUN, CHECK and DONE.
- REQ-017 SHALL move IDLE->HOLD, or DONE->HOLD, on a clock edge with start=1; entering HOLD clears pass, fail_idx, err_count and the counters.
- REQ-018 SHALL stay in HOLD for exactly RESET_CYCLES cycles, in RUN for exactly RUN_CYCLES cycles, and in CHECK for NUM_REGS cycles, then enter DONE; start is ignored in HOLD, RUN and CHECK.
- REQ-019 SHALL drive core_reset=1 in IDLE and HOLD and 0 in RUN, CHECK and DONE.
- REQ-020 SHALL drive core_stall=1 in CHECK and DONE only.
- REQ-021 SHALL drive busy=1 in HOLD, RUN and CHECK, and done=1 only in DONE.
- REQ-022 SHALL have chk_addr step 0..NUM_REGS-1, one per CHECK cycle, starting at 0 on CHECK entry; chk_addr SHALL be 0 outside CHECK.
- REQ-023 SHALL compare each CHECK cycle with exp_mask=1: a mismatch occurs when dbg_data != exp_data over all DATA_WIDTH bits, and the comparison result is registered on the edge that ends that cycle.
- REQ-024 SHALL, on a mismatch, increment err_count, and SHALL load fail_idx with chk_addr only on the first mismatch of the run.
- REQ-025 SHALL set pass=1 on DONE entry iff err_count=0; LED SHALL equal done AND pass.
- REQ-026 SHALL make DONE visible RESET_CYCLES+RUN_CYCLES+NUM_REGS edges after the start edge.
- REQ-027 SHALL hold all outputs stable in DONE until start or reset.

Reset
- REQ-028 SHALL, on reset=1 in any state and at any time, enter IDLE asynchronously.
- REQ-029 SHALL give these reset values: core_reset=1, core_stall=0, chk_addr=0, busy=0, done=0, pass=0, fail_idx=0, err_count=0, LED=0.
- REQ-030 SHALL discard any test in progress when reset is asserted mid-operation; there is no resume.

Configuration
- REQ-031 SHALL, with macro SELFTEST_STOP_ON_FAIL_EN defined, enter DONE on the edge that registers the first mismatch, giving err_count=1, pass=0 and fail_idx equal to that index.
- REQ-032 SHALL, without SELFTEST_STOP_ON_FAIL_EN, always walk all NUM_REGS registers and count every mismatch.

Verification (DATA_WIDTH=32, NUM_REGS=4, RESET_CYCLES=2, RUN_CYCLES=5, start pulsed at edge 0)
- REQ-033 SHALL cover: all registers match, mask all 1 -> core_reset falls at edge 2, core_stall rises at edge 7, done=1, pass=1, LED=1 and err_count=0 at edge 11.
- REQ-034 SHALL cover: reg 2 reads 0xFEDCBA98 against expected 0x0FEDCBA9 -> pass=0, fail_idx=2, err_count=1 and LED=0 at edge 11.
- REQ-035 SHALL cover: mismatches at reg 1 and reg 3 -> without the macro, done at edge 11 with err_count=2 and fail_idx=1; with the macro, done at edge 9 with err_count=1 and fail_idx=1.
- REQ-036 SHALL cover: a mismatch at reg 3 with exp_mask=0 for reg 3 -> pass=1 and err_count=0.
- REQ-037 SHALL cover: reset raised between edges 4 and 5 (RUN state) -> core_reset=1, busy=0 and done=0 immediately without a clock edge; a fresh start then gives done at start+11.
- REQ-038 SHALL cover: start held high during RUN is ignored (done still at edge 11); start in DONE restarts, clearing done, pass and err_count on the next edge.
